// File: rtl/fim_dpram_be.sv
// Simple dual-port RAM with per-byte write enables, 1..3 cycle read latency,
// same-cycle byte-merged write bypass and an optional post-reset clear sequencer.
module fim_dpram_be #(
   parameter int    DATA_WIDTH     = 64,
   parameter int    DEPTH_LOG2     = 5,
   parameter int    READ_LATENCY   = 1,
   parameter string RAM_STYLE      = "AUTO",
   parameter bit    CLEAR_ON_RESET = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst,
   output logic                    init_done,
   input  logic                    w_req,
   input  logic [DEPTH_LOG2-1:0]   w_address,
   input  logic [DATA_WIDTH-1:0]   w_data,
   input  logic [DATA_WIDTH/8-1:0] w_byteen,
   input  logic                    r_req,
   input  logic [DEPTH_LOG2-1:0]   r_address,
   output logic [DATA_WIDTH-1:0]   r_data,
   output logic                    r_valid
);

   localparam int NB    = DATA_WIDTH / 8;
   localparam int DEPTH = 1 << DEPTH_LOG2;

   if (DATA_WIDTH <= 0 || DATA_WIDTH % 8 != 0) begin : g_bad_width
      $error("fim_dpram_be: DATA_WIDTH must be a positive multiple of 8");
   end
   if (READ_LATENCY < 1 || READ_LATENCY > 3) begin : g_bad_latency
      $error("fim_dpram_be: READ_LATENCY must be 1..3");
   end
   if (RAM_STYLE != "AUTO" && RAM_STYLE != "MLAB" && RAM_STYLE != "M20K" &&
       RAM_STYLE != "LUTRAM") begin : g_bad_style
      $error("fim_dpram_be: RAM_STYLE must be AUTO, MLAB, M20K or LUTRAM");
   end

   typedef enum logic {ST_CLEAR, ST_READY} state_t;

   state_t                  state, state_nxt;
   logic [DEPTH_LOG2-1:0]   clr_cnt, clr_cnt_nxt;
   logic                    clr_we;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_CLEAR;
         clr_cnt <= '0;
      end else begin
         state   <= state_nxt;
         clr_cnt <= clr_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      clr_cnt_nxt = clr_cnt;
      clr_we      = 1'b0;
      case (state)
         ST_CLEAR: begin
            if (!CLEAR_ON_RESET) begin
               state_nxt = ST_READY;
            end else begin
               clr_we      = 1'b1;
               clr_cnt_nxt = clr_cnt + DEPTH_LOG2'(1);
               if (clr_cnt == '1) state_nxt = ST_READY;
            end
         end
         default: state_nxt = ST_READY;
      endcase
   end

   assign init_done = (state == ST_READY);

   logic                  w_fire, r_fire, mem_we;
   logic [DEPTH_LOG2-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_data;
   logic [NB-1:0]         mem_be;

   assign w_fire   = w_req & init_done;
   assign r_fire   = r_req & init_done;
   assign mem_we   = clr_we | w_fire;
   assign mem_addr = clr_we ? clr_cnt : w_address;
   assign mem_data = clr_we ? '0 : w_data;
   assign mem_be   = clr_we ? '1 : w_byteen;

   (* ramstyle = RAM_STYLE *) logic [DATA_WIDTH-1:0] mem [DEPTH];

   // NOTE: the storage array has no reset so it maps onto a RAM macro; zeroing is the clear FSM's job.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < NB; i++) begin
            if (mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_data[8*i +: 8];
         end
      end
   end

   // Array output plus same-cycle write bytes travel together; merged only at the output.
   logic [DATA_WIDTH-1:0]   ram_q      [READ_LATENCY];
   logic [DATA_WIDTH-1:0]   byp_data_q [READ_LATENCY];
   logic [NB-1:0]           byp_be_q   [READ_LATENCY];
   logic [READ_LATENCY-1:0] vld_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q <= '0;
         for (int k = 0; k < READ_LATENCY; k++) begin
            ram_q[k]      <= '0;
            byp_data_q[k] <= '0;
            byp_be_q[k]   <= '0;
         end
      end else begin
         vld_q[0] <= r_fire;
         if (r_fire) begin
            ram_q[0]      <= mem[r_address];
            byp_data_q[0] <= w_data;
            byp_be_q[0]   <= (w_fire && w_address == r_address) ? w_byteen : '0;
         end
         for (int k = 1; k < READ_LATENCY; k++) begin
            vld_q[k] <= vld_q[k-1];
            if (vld_q[k-1]) begin
               ram_q[k]      <= ram_q[k-1];
               byp_data_q[k] <= byp_data_q[k-1];
               byp_be_q[k]   <= byp_be_q[k-1];
            end
         end
      end
   end

   assign r_valid = vld_q[READ_LATENCY-1];

   always_comb begin
      r_data = ram_q[READ_LATENCY-1];
      for (int i = 0; i < NB; i++) begin
         if (byp_be_q[READ_LATENCY-1][i])
            r_data[8*i +: 8] = byp_data_q[READ_LATENCY-1][8*i +: 8];
      end
   end

endmodule
